// File: rtl/nfet_pkg.sv
// Shared constants and the pull-up rise-time helper for the nfet switch-level model.
package nfet_pkg;

  localparam int RES_UNIT_OHMS = 1000;
  localparam int SWITCH_CNT_W  = 16;
  // Holds RISE_CYCLES up to 800 (100k ohm pull-up driving 8 gate loads)
  localparam int RISE_CNT_W    = 10;

  function automatic int rise_cycles(input int r_pullup, input int load);
    int cyc;
    cyc = (r_pullup * load) / RES_UNIT_OHMS;
    return (cyc < 1) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/nfet_delay_line.sv
// Gate propagation delay: DELAY-stage shift register, cleared asynchronously.
module nfet_delay_line #(
  parameter int DELAY = 1
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic d_i,
  output logic q_o
);

  logic [DELAY-1:0] shift_q;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      shift_q <= '0;
    end else begin
      shift_q[0] <= d_i;
      for (int i = 1; i < DELAY; i++) begin
        shift_q[i] <= shift_q[i-1];
      end
    end
  end

  assign q_o = shift_q[DELAY-1];

endmodule

// File: rtl/nfet_switch.sv
// Switch-level n-channel FET with resistive drain pull-up; drain pulls to the
// source level while conducting and recharges after an RC-derived cycle count.
module nfet_switch
  import nfet_pkg::*;
#(
  parameter int DELAY    = 1,
  parameter int R_PULLUP = 1000,
  parameter int LOAD     = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        source,
  input  logic        gate,
  output logic        drain,
  output logic        conduct,
  output logic [15:0] switch_count
);

  localparam int RISE_CYCLES = rise_cycles(R_PULLUP, LOAD);
  localparam logic [RISE_CNT_W-1:0]   RISE_MAX = RISE_CNT_W'(RISE_CYCLES);
  localparam logic [SWITCH_CNT_W-1:0] CNT_MAX  = '1;

  logic                    gate_dly;
  logic                    conduct_q, conduct_d;
  logic                    drain_q, drain_d;
  logic [RISE_CNT_W-1:0]   rise_q, rise_d;
  logic [SWITCH_CNT_W-1:0] cnt_q, cnt_d;

  nfet_delay_line #(
    .DELAY(DELAY)
  ) u_gate_dly (
    .clk_i (clk),
    .nrst_i(nrst),
    .d_i   (gate),
    .q_o   (gate_dly)
  );

  always_comb begin
    conduct_d = gate_dly & ~source;
    rise_d    = rise_q;
    drain_d   = drain_q;
    cnt_d     = cnt_q;
    // A conducting channel wins over any rise in progress and discharges at once
    if (conduct_d) begin
      rise_d  = '0;
      drain_d = 1'b0;
    end else if (!conduct_q) begin
      if (rise_q != RISE_MAX) begin
        rise_d = rise_q + RISE_CNT_W'(1);
      end
      if (rise_d == RISE_MAX) begin
        drain_d = 1'b1;
      end
    end
    if ((drain_d != drain_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + SWITCH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      conduct_q <= 1'b0;
      drain_q   <= 1'b1;
      rise_q    <= RISE_MAX;
      cnt_q     <= '0;
    end else begin
      conduct_q <= conduct_d;
      drain_q   <= drain_d;
      rise_q    <= rise_d;
      cnt_q     <= cnt_d;
    end
  end

  assign drain        = drain_q;
  assign conduct      = conduct_q;
  assign switch_count = cnt_q;

endmodule

// File: tb/tb_nfet_switch.sv
// Scoreboard bench for nfet_switch: stimulus queues expected outputs, a monitor compares.
module tb_nfet_switch;

  logic clk = 1'b0;
  logic nrst;
  logic gate0, source0, gate1, gate2, gate3, gate4;
  logic zero_src;

  logic [4:0] drain_w, conduct_w;
  logic [15:0] cnt_w [5];

  typedef struct {
    int          dut;
    logic        dr;
    logic        co;
    logic [15:0] cnt;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event sample_ev;

  always #5 clk = ~clk;

  // dut 0: defaults
  nfet_switch u_def (
    .clk(clk), .nrst(nrst), .source(source0), .gate(gate0),
    .drain(drain_w[0]), .conduct(conduct_w[0]), .switch_count(cnt_w[0])
  );

  // dut 1: DELAY=2, RISE_CYCLES=10
  nfet_switch #(.DELAY(2), .R_PULLUP(10000), .LOAD(1)) u_d2 (
    .clk(clk), .nrst(nrst), .source(zero_src), .gate(gate1),
    .drain(drain_w[1]), .conduct(conduct_w[1]), .switch_count(cnt_w[1])
  );

  // dut 2: DELAY=3, RISE_CYCLES=3
  nfet_switch #(.DELAY(3), .R_PULLUP(1000), .LOAD(3)) u_ab (
    .clk(clk), .nrst(nrst), .source(zero_src), .gate(gate2),
    .drain(drain_w[2]), .conduct(conduct_w[2]), .switch_count(cnt_w[2])
  );

  // dut 3/4: series stack, lower drain feeds upper source
  nfet_switch u_lo (
    .clk(clk), .nrst(nrst), .source(zero_src), .gate(gate3),
    .drain(drain_w[3]), .conduct(conduct_w[3]), .switch_count(cnt_w[3])
  );

  nfet_switch u_hi (
    .clk(clk), .nrst(nrst), .source(drain_w[3]), .gate(gate4),
    .drain(drain_w[4]), .conduct(conduct_w[4]), .switch_count(cnt_w[4])
  );

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (drain_w[e.dut] !== e.dr || conduct_w[e.dut] !== e.co || cnt_w[e.dut] !== e.cnt) begin
          n_fail++;
          $display("FAIL %s dut%0d: got drain=%b conduct=%b count=%0d, expected drain=%b conduct=%b count=%0d",
                   e.nm, e.dut, drain_w[e.dut], conduct_w[e.dut], cnt_w[e.dut], e.dr, e.co, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic expect_out(input int dut, input logic dr, input logic co, input int cnt, input string nm);
    exp_t e;
    e.dut = dut; e.dr = dr; e.co = co; e.cnt = cnt[15:0]; e.nm = nm;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    ->sample_ev;
    #1;
  endtask

  task automatic edge_();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    gate0 = 1'b0; source0 = 1'b0;
    gate1 = 1'b0; gate2 = 1'b0; gate3 = 1'b0; gate4 = 1'b0;
    edge_();
    edge_();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  logic       t2_dr [10] = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 0};
  logic       t2_co [10] = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 1};
  int         t2_cn [10] = '{0, 1, 1, 1, 2, 2, 3, 3, 4, 5};

  initial begin : stimulus
    zero_src = 1'b0;
    nrst = 1'b1;
    gate0 = 1'b0; source0 = 1'b0;
    gate1 = 1'b0; gate2 = 1'b0; gate3 = 1'b0; gate4 = 1'b0;

    // Defaults: fall, rise, source-high pass-through, re-fall
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      gate0   = (c <= 2) || (c >= 6);
      source0 = (c == 8) || (c == 9);
      edge_();
      expect_out(0, t2_dr[c-1], t2_co[c-1], t2_cn[c-1], $sformatf("default_c%0d", c));
      sample();
    end

    // Async reset with gate high, hold until first edge after release
    @(negedge clk);
    nrst = 1'b0; gate0 = 1'b1; source0 = 1'b0;
    #1;
    expect_out(0, 1'b1, 1'b0, 0, "reset_async");
    sample();
    edge_();
    expect_out(0, 1'b1, 1'b0, 0, "reset_held");
    sample();
    @(negedge clk);
    nrst = 1'b1;
    #2;
    expect_out(0, 1'b1, 1'b0, 0, "reset_released_no_edge");
    sample();
    edge_();
    expect_out(0, 1'b1, 1'b0, 0, "after_release_e1");
    sample();
    edge_();
    expect_out(0, 1'b0, 1'b1, 1, "after_release_e2");
    sample();

    // DELAY=2, RISE=10: 5-cycle gate pulse
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      gate1 = (c <= 5);
      edge_();
      expect_out(1, (c >= 3 && c < 18) ? 1'b0 : 1'b1, (c >= 3 && c < 8),
                 (c < 3) ? 0 : ((c < 18) ? 1 : 2), $sformatf("d2_rise10_c%0d", c));
      sample();
    end

    // Rise abort on DELAY=3, RISE=3
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      gate2 = (c <= 4) || (c >= 7);
      edge_();
      expect_out(2, (c < 4), (c >= 4 && c < 8) || (c >= 10),
                 (c < 4) ? 0 : 1, $sformatf("abort_c%0d", c));
      sample();
    end

    // Series stack
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      gate3 = (c >= 4);
      gate4 = (c <= 6);
      edge_();
      expect_out(3, (c < 5), (c >= 5), (c < 5) ? 0 : 1, $sformatf("stack_lo_c%0d", c));
      expect_out(4, !(c == 6 || c == 7 || c == 8), (c == 6 || c == 7),
                 (c < 6) ? 0 : ((c < 9) ? 1 : 2), $sformatf("stack_hi_c%0d", c));
      sample();
    end

    // Async reset in the middle of a 10-cycle rise
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      gate1 = (c <= 5);
      edge_();
    end
    expect_out(1, 1'b0, 1'b0, 1, "midrise_before_reset");
    sample();
    nrst = 1'b0;
    #1;
    expect_out(1, 1'b1, 1'b0, 0, "midrise_async_reset");
    sample();
    @(negedge clk);
    nrst = 1'b1;
    gate1 = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      edge_();
      expect_out(1, 1'b1, 1'b0, 0, $sformatf("post_reset_idle_c%0d", c));
      sample();
    end

    #5;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
